sata_host_oobfsm: RTL and testbench



---
 rtl/sata_host_oobfsm_if.sv | 23 ++
 rtl/sata_host_oobfsm.sv | 117 +++++++++++
 tb/tb_sata_host_oobfsm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sata_host_oobfsm_if.sv
// sata_host_oobfsm_if: OOB handshake bus; master = host FSM, slave = device/receive side
interface sata_host_oobfsm_if;
  logic       i_comreset_req;
  logic       i_cominit_det;
  logic       i_comwake_det;
  logic       i_align_det;
  logic       i_sync_det;
  logic       o_tx_elecidle;
  logic       o_tx_burst;
  logic       o_tx_d10_2;
  logic       o_tx_align;
  logic       o_link_up;
  logic [2:0] o_state;
  logic [7:0] o_retries;
  modport master (
    input  i_comreset_req, i_cominit_det, i_comwake_det, i_align_det, i_sync_det,
    output o_tx_elecidle, o_tx_burst, o_tx_d10_2, o_tx_align, o_link_up, o_state, o_retries
  );
  modport slave (
    output i_comreset_req, i_cominit_det, i_comwake_det, i_align_det, i_sync_det,
    input  o_tx_elecidle, o_tx_burst, o_tx_d10_2, o_tx_align, o_link_up, o_state, o_retries
  );
endinterface

// File: rtl/sata_host_oobfsm.sv
// sata_host_oobfsm: host SATA OOB sequencer (COMRESET, COMWAKE, D10.2, ALIGN, ready); ports i_clk, i_reset, bus (master)
module sata_host_oobfsm #(
  parameter int BURST_CYCLES  = 16,
  parameter int RESET_GAP     = 48,
  parameter int WAKE_GAP      = 16,
  parameter int NBURSTS       = 6,
  parameter int RETRY_CYCLES  = 4096,
  parameter int ALIGN_TIMEOUT = 8192
) (
  input logic                i_clk,
  input logic                i_reset,
  sata_host_oobfsm_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, COMRESET, WAIT_COMINIT, COMWAKE, WAIT_COMWAKE, SEND_D10, SEND_ALIGN, READY
  } state_t;
  localparam int M1   = RETRY_CYCLES > ALIGN_TIMEOUT ? RETRY_CYCLES : ALIGN_TIMEOUT;
  localparam int M2   = BURST_CYCLES > RESET_GAP ? BURST_CYCLES : RESET_GAP;
  localparam int M3   = M2 > WAKE_GAP ? M2 : WAKE_GAP;
  localparam int MAXC = M1 > M3 ? M1 : M3;
  localparam int CW   = $clog2(MAXC);
  localparam int IW   = $clog2(NBURSTS + 1);
  state_t          r_state, w_state;
  logic            r_gap, w_gap, r_armed, w_armed, r_cw_q;
  logic            w_retry, w_restart, w_phase_end, w_fall;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [IW-1:0]   r_idx, w_idx;
  logic [7:0]      r_retries;
  logic            r_elecidle, r_burst, r_d10, r_align, r_link;
  always_comb begin
    w_phase_end = r_cnt == CW'(r_gap ? (r_state == COMRESET ? RESET_GAP : WAKE_GAP) - 1 : BURST_CYCLES - 1);
    w_fall      = r_armed & r_cw_q & ~bus.i_comwake_det;
    w_state     = r_state;
    w_gap       = r_gap;
    w_idx       = r_idx;
    w_cnt       = r_cnt;
    w_retry     = 1'b0;
    w_armed     = r_armed | (bus.i_comwake_det & ~r_cw_q);
    case (r_state)
      IDLE: w_state = COMRESET;
      COMRESET, COMWAKE: begin
        w_cnt = w_phase_end ? '0 : r_cnt + 1'b1;
        w_gap = r_gap ^ w_phase_end;
        if (w_phase_end && r_gap) begin
          w_idx = r_idx + 1'b1;
          if (r_idx == IW'(NBURSTS - 1)) w_state = r_state == COMRESET ? WAIT_COMINIT : WAIT_COMWAKE;
        end
      end
      WAIT_COMINIT: begin
        w_cnt   = r_cnt + 1'b1;
        w_retry = ~bus.i_cominit_det && r_cnt == CW'(RETRY_CYCLES - 1);
        w_state = bus.i_cominit_det ? COMWAKE : w_retry ? COMRESET : r_state;
      end
      WAIT_COMWAKE: begin
        w_cnt   = r_cnt + 1'b1;
        w_retry = ~w_fall && r_cnt == CW'(RETRY_CYCLES - 1);
        w_state = w_fall ? SEND_D10 : w_retry ? COMRESET : r_state;
      end
      SEND_D10: begin
        w_cnt   = r_cnt + 1'b1;
        w_retry = ~bus.i_align_det && r_cnt == CW'(ALIGN_TIMEOUT - 1);
        w_state = bus.i_align_det ? SEND_ALIGN : w_retry ? COMRESET : r_state;
      end
      SEND_ALIGN: w_state = bus.i_sync_det ? READY : r_state;
      READY:      w_state = bus.i_cominit_det ? COMRESET : r_state;
      default:    w_state = IDLE;
    endcase
    w_restart = bus.i_comreset_req && r_state != IDLE;
    if (w_restart) begin
      w_state = COMRESET;
      w_retry = 1'b0;
    end
    // any entry (including COMRESET re-entry on request) restarts timer, burst index and edge arming
    if (w_restart || w_state != r_state) begin
      w_cnt   = '0;
      w_gap   = 1'b0;
      w_idx   = '0;
      w_armed = 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_gap      <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_armed    <= 1'b0;
      r_cw_q     <= 1'b0;
      r_retries  <= '0;
      r_elecidle <= 1'b1;
      r_burst    <= 1'b0;
      r_d10      <= 1'b0;
      r_align    <= 1'b0;
      r_link     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_gap      <= w_gap;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_armed    <= w_armed;
      r_cw_q     <= bus.i_comwake_det;
      r_retries  <= r_retries + {7'd0, w_retry && r_retries != 8'hFF};
      r_elecidle <= w_state inside {IDLE, WAIT_COMINIT, WAIT_COMWAKE} || ((w_state == COMRESET || w_state == COMWAKE) && w_gap);
      r_burst    <= (w_state == COMRESET || w_state == COMWAKE) && !w_gap;
      r_d10      <= w_state == SEND_D10;
      r_align    <= w_state == SEND_ALIGN;
      r_link     <= w_state == READY;
    end
  end
  assign bus.o_state       = r_state;
  assign bus.o_retries     = r_retries;
  assign bus.o_tx_elecidle = r_elecidle;
  assign bus.o_tx_burst    = r_burst;
  assign bus.o_tx_d10_2    = r_d10;
  assign bus.o_tx_align    = r_align;
  assign bus.o_link_up     = r_link;
endmodule

// File: tb/tb_sata_host_oobfsm.sv
// tb_sata_host_oobfsm: directed per-cycle scoreboard bench for sata_host_oobfsm
module tb_sata_host_oobfsm;
  localparam int BC = 4, RG = 6, WG = 3, NB = 4, RC = 32, AT = 64;
  typedef struct {
    string      tag;
    logic [15:0] v;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  r;
  logic [15:0] obs;
  string       tag;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  sata_host_oobfsm_if bus();
  sata_host_oobfsm #(
    .BURST_CYCLES(BC), .RESET_GAP(RG), .WAKE_GAP(WG), .NBURSTS(NB),
    .RETRY_CYCLES(RC), .ALIGN_TIMEOUT(AT)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  assign obs = {bus.o_state, bus.o_tx_elecidle, bus.o_tx_burst, bus.o_tx_d10_2,
                bus.o_tx_align, bus.o_link_up, bus.o_retries};
  function automatic logic [15:0] mk(input logic [2:0] st, input logic b, input logic [7:0] rr);
    logic seq;
    logic ei;
    seq = st == 3'd1 || st == 3'd3;
    ei  = st == 3'd0 || st == 3'd2 || st == 3'd4 || (seq && !b);
    return {st, ei, seq && b, st == 3'd5, st == 3'd6, st == 3'd7, rr};
  endfunction
  task automatic cyc(input logic [15:0] e);
    exp_t x;
    sb.push_back('{tag, e});
    @(negedge clk);
    bus.i_comreset_req = 1'b0;
    bus.i_cominit_det  = 1'b0;
    bus.i_align_det    = 1'b0;
    bus.i_sync_det     = 1'b0;
    x = sb.pop_front();
    n_checks++;
    assert (obs === x.v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
    end
  endtask
  task automatic bseq(input logic [2:0] st, input int gap, input logic [7:0] rr);
    for (int n = 0; n < NB; n++) begin
      repeat (BC) cyc(mk(st, 1'b1, rr));
      repeat (gap) cyc(mk(st, 1'b0, rr));
    end
  endtask
  task automatic to_d10(input logic [7:0] rr);
    repeat (2) cyc(mk(3'd2, 1'b0, rr));
    bus.i_cominit_det = 1'b1;
    bseq(3'd3, WG, rr);
    repeat (2) cyc(mk(3'd4, 1'b0, rr));
    bus.i_comwake_det = 1'b1;
    repeat (3) cyc(mk(3'd4, 1'b0, rr));
    bus.i_comwake_det = 1'b0;
    cyc(mk(3'd5, 1'b0, rr));
  endtask
  initial begin
    rst = 1'b1;
    bus.i_comreset_req = 1'b0;
    bus.i_cominit_det  = 1'b0;
    bus.i_comwake_det  = 1'b0;
    bus.i_align_det    = 1'b0;
    bus.i_sync_det     = 1'b0;
    tag = "reset";
    repeat (2) cyc(mk(3'd0, 1'b0, 8'd0));
    rst = 1'b0;
    tag = "nominal_comreset";
    bseq(3'd1, RG, 8'd0);
    tag = "nominal_wake";
    to_d10(8'd0);
    tag = "nominal_d10";
    repeat (3) cyc(mk(3'd5, 1'b0, 8'd0));
    bus.i_align_det = 1'b1;
    tag = "nominal_align";
    repeat (3) cyc(mk(3'd6, 1'b0, 8'd0));
    bus.i_sync_det = 1'b1;
    tag = "nominal_ready";
    repeat (3) cyc(mk(3'd7, 1'b0, 8'd0));
    tag = "ready_cominit";
    bus.i_cominit_det = 1'b1;
    bseq(3'd1, RG, 8'd0);
    tag = "cominit_timeout";
    repeat (RC) cyc(mk(3'd2, 1'b0, 8'd0));
    bseq(3'd1, RG, 8'd1);
    tag = "reset_in_comwake";
    repeat (2) cyc(mk(3'd2, 1'b0, 8'd1));
    bus.i_cominit_det = 1'b1;
    for (int n = 0; n < 2; n++) begin
      repeat (BC) cyc(mk(3'd3, 1'b1, 8'd1));
      repeat (WG) cyc(mk(3'd3, 1'b0, 8'd1));
    end
    repeat (2) cyc(mk(3'd3, 1'b1, 8'd1));
    rst = 1'b1;
    cyc(mk(3'd0, 1'b0, 8'd0));
    rst = 1'b0;
    tag = "restart_after_reset";
    bseq(3'd1, RG, 8'd0);
    to_d10(8'd0);
    tag = "align_timeout";
    repeat (AT - 1) cyc(mk(3'd5, 1'b0, 8'd0));
    bseq(3'd1, RG, 8'd1);
    tag = "req_vs_align";
    to_d10(8'd1);
    bus.i_comreset_req = 1'b1;
    bus.i_align_det    = 1'b1;
    repeat (BC) cyc(mk(3'd1, 1'b1, 8'd1));
    repeat (2) cyc(mk(3'd1, 1'b0, 8'd1));
    tag = "req_mid_comreset";
    bus.i_comreset_req = 1'b1;
    bseq(3'd1, RG, 8'd1);
    tag = "ready_req";
    to_d10(8'd1);
    bus.i_align_det = 1'b1;
    cyc(mk(3'd6, 1'b0, 8'd1));
    bus.i_sync_det = 1'b1;
    cyc(mk(3'd7, 1'b0, 8'd1));
    bus.i_comreset_req = 1'b1;
    bseq(3'd1, RG, 8'd1);
    tag = "retry_saturate";
    r = 8'd1;
    repeat (300) begin
      repeat (RC) cyc(mk(3'd2, 1'b0, r));
      r = (r == 8'hFF) ? 8'hFF : r + 8'd1;
      bseq(3'd1, RG, r);
    end
    tag = "final_reset";
    rst = 1'b1;
    cyc(mk(3'd0, 1'b0, 8'd0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
